// File: rtl/mem_server_l7_if.sv
// Request/response channel between a memory client and mem_server_l7.
// Both channels use val/rdy handshakes; a message moves on val & rdy.
interface mem_server_l7_if #(
    parameter int p_opaq_bits = 8
);
    // Request channel (client -> server)
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_opaq_bits-1:0] req_opaque;
    logic [31:0]            req_addr;
    logic [3:0]             req_strb;
    logic [31:0]            req_data;

    // Response channel (server -> client)
    logic                   resp_val;
    logic                   resp_rdy;
    logic                   resp_op;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic [31:0]            resp_addr;
    logic [3:0]             resp_strb;
    logic [31:0]            resp_data;

    modport server (
        input  req_val, req_op, req_opaque, req_addr, req_strb, req_data,
        output req_rdy,
        output resp_val, resp_op, resp_opaque, resp_addr, resp_strb, resp_data,
        input  resp_rdy
    );

    modport client (
        output req_val, req_op, req_opaque, req_addr, req_strb, req_data,
        input  req_rdy,
        input  resp_val, resp_op, resp_opaque, resp_addr, resp_strb, resp_data,
        output resp_rdy
    );
endinterface

// File: rtl/mem_server_l7.sv
// In-order memory responder: word-addressed storage with byte-strobed
// writes, a backdoor preload port, and a ring of pending responses that
// each become visible a fixed number of cycles after their request.
module mem_server_l7 #(
    parameter int p_opaq_bits = 8,
    parameter int p_num_words = 256,
    parameter int p_latency   = 1,
    parameter int p_depth     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_server_l7_if.server        mem,
    input  logic                   init_en,
    input  logic [31:0]            init_addr,
    input  logic [31:0]            init_data
);
    localparam logic MEM_MSG_READ  = 1'b0;
    localparam logic MEM_MSG_WRITE = 1'b1;

    localparam int AW = $clog2(p_num_words);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int OW = $clog2(p_depth + 1);
    localparam int CW = (p_latency > 1) ? $clog2(p_latency) : 1;

    // Ring pointers and occupancy (in flight plus waiting to be taken)
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [OW-1:0] r_occ;

    // Ring payload; contents are meaningless while the slot is free
    logic                   r_buf_op     [p_depth];
    logic [p_opaq_bits-1:0] r_buf_opaque [p_depth];
    logic [31:0]            r_buf_addr   [p_depth];
    logic [3:0]             r_buf_strb   [p_depth];
    logic [31:0]            r_buf_data   [p_depth];

    logic [CW-1:0] w_cnt [p_depth];

    logic          w_accept;
    logic          w_xfer;
    logic          w_wr_en;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_init_idx;
    logic [31:0]   w_rd_word;
    logic [PW-1:0] w_head_next;
    logic [PW-1:0] w_tail_next;
    logic          w_unused_init;

    // Ready depends only on registered occupancy and the backdoor enable,
    // never on resp_rdy, so a full ring stays closed for one extra cycle.
    assign mem.req_rdy  = rst & ~init_en & (r_occ < OW'(p_depth));
    assign mem.resp_val = (r_occ != '0) & (w_cnt[r_head] == '0);

    assign mem.resp_op     = r_buf_op[r_head];
    assign mem.resp_opaque = r_buf_opaque[r_head];
    assign mem.resp_addr   = r_buf_addr[r_head];
    assign mem.resp_strb   = r_buf_strb[r_head];
    assign mem.resp_data   = r_buf_data[r_head];

    assign w_accept   = mem.req_val & mem.req_rdy;
    assign w_xfer     = mem.resp_val & mem.resp_rdy;
    assign w_wr_en    = w_accept & (mem.req_op == MEM_MSG_WRITE);
    assign w_req_idx  = mem.req_addr[2 +: AW];
    assign w_init_idx = init_addr[2 +: AW];

    // Byte offset and high bits of the backdoor address select nothing
    assign w_unused_init = ^init_addr;

    assign w_head_next = (r_head == PW'(p_depth - 1)) ? '0 : r_head + 1'b1;
    assign w_tail_next = (r_tail == PW'(p_depth - 1)) ? '0 : r_tail + 1'b1;

    // Storage split into four byte lanes so each strobe bit is a lane enable
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [p_num_words];

            // Lane write: backdoor preload, or a strobed request write
            always_ff @(posedge clk) begin
                if (init_en) begin
                    r_lane[w_init_idx] <= init_data[8*gi +: 8];
                end else if (w_wr_en && mem.req_strb[gi]) begin
                    r_lane[w_req_idx] <= mem.req_data[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_lane[w_req_idx];
        end
    endgenerate

    // Per-slot latency countdown; keeps running even while the head stalls
    generate
        for (genvar gi = 0; gi < p_depth; gi++) begin : g_slot
            logic [CW-1:0] r_cnt;

            // Load on accept into this slot, otherwise count down to zero
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (w_accept && (r_tail == PW'(gi))) begin
                    r_cnt <= CW'(p_latency - 1);
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    // Capture the response at accept; the array read is registered here
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_op[r_tail]     <= mem.req_op;
            r_buf_opaque[r_tail] <= mem.req_opaque;
            r_buf_addr[r_tail]   <= mem.req_addr;
            r_buf_strb[r_tail]   <= mem.req_strb;
            r_buf_data[r_tail]   <= (mem.req_op == MEM_MSG_READ) ? w_rd_word : 32'h0;
        end
    end

    // Advance ring pointers and track occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= w_tail_next;
            end
            if (w_xfer) begin
                r_head <= w_head_next;
            end
            case ({w_accept, w_xfer})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_server_l7.sv
// Bench for mem_server_l7: two instances (latency 1 / depth 2 and
// latency 2 / depth 3) driven from shared tasks, with a scoreboard of
// expected responses popped by a monitor on every response transfer.
module tb_mem_server_l7;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef struct packed {
        logic        op;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } msg_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_val  [2];
    logic        req_rdy  [2];
    logic        req_op   [2];
    logic [7:0]  req_opq  [2];
    logic [31:0] req_addr [2];
    logic [3:0]  req_strb [2];
    logic [31:0] req_data [2];
    logic        resp_val [2];
    logic        resp_rdy [2];
    msg_t        resp_msg [2];
    logic        init_en  [2];
    logic [31:0] init_addr[2];
    logic [31:0] init_data[2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mem_server_l7_if #(.p_opaq_bits(8)) u_if ();

            assign u_if.req_val    = req_val[gi];
            assign u_if.req_op     = req_op[gi];
            assign u_if.req_opaque = req_opq[gi];
            assign u_if.req_addr   = req_addr[gi];
            assign u_if.req_strb   = req_strb[gi];
            assign u_if.req_data   = req_data[gi];
            assign u_if.resp_rdy   = resp_rdy[gi];
            assign req_rdy[gi]     = u_if.req_rdy;
            assign resp_val[gi]    = u_if.resp_val;
            assign resp_msg[gi]    = {u_if.resp_op, u_if.resp_opaque, u_if.resp_addr,
                                      u_if.resp_strb, u_if.resp_data};

            mem_server_l7 #(
                .p_opaq_bits(8),
                .p_num_words(256),
                .p_latency  ((gi == 0) ? 1 : 2),
                .p_depth    ((gi == 0) ? 2 : 3)
            ) u_dut (
                .clk      (clk),
                .rst      (rst_n),
                .mem      (u_if),
                .init_en  (init_en[gi]),
                .init_addr(init_addr[gi]),
                .init_data(init_data[gi])
            );
        end
    endgenerate

    logic [31:0] model_mem [2][256];
    msg_t        exp_q0[$];
    msg_t        exp_q1[$];
    int          rcyc_q0[$];
    int          rcyc_q1[$];
    logic [31:0] last_data [2];
    int          n_checks = 0;
    int          n_errors = 0;
    int          acc;
    int          acc3 [4];
    int          acc4 [3];
    int          r0, r1, r2;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic msg_t exp_pop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic int rcyc_size(input int d);
        return (d == 0) ? rcyc_q0.size() : rcyc_q1.size();
    endfunction

    function automatic int pop_rcyc(input int d);
        if (d == 0) return rcyc_q0.pop_front();
        return rcyc_q1.pop_front();
    endfunction

    task automatic clear_rcyc(input int d);
        if (d == 0) rcyc_q0.delete();
        else        rcyc_q1.delete();
    endtask

    // Monitor: sample just before each rising edge and score every transfer
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (resp_val[d] && resp_rdy[d]) begin
                    if (exp_size(d) == 0) begin
                        check_val($sformatf("resp_unexpected%0d", d), 128'(resp_val[d]), 128'(1'b0));
                    end else begin
                        check_val($sformatf("resp_msg%0d", d), 128'(resp_msg[d]), 128'(exp_pop(d)));
                        if (d == 0) rcyc_q0.push_back(cyc);
                        else        rcyc_q1.push_back(cyc);
                        last_data[d] = resp_msg[d].data;
                    end
                    $display("resp dut%0d cyc %0d op %0d opq %02h addr %08h data %08h",
                             d, cyc, resp_msg[d].op, resp_msg[d].opq, resp_msg[d].addr, resp_msg[d].data);
                end
            end
        end
    end

    task automatic init_wr(input int d, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        init_en[d]   = 1'b1;
        init_addr[d] = a;
        init_data[d] = v;
        #1;
        check_val("init_rdy_low", 128'(req_rdy[d]), 128'(1'b0));
        model_mem[d][a[9:2]] = v;
        @(posedge clk);
        #1;
        init_en[d] = 1'b0;
    endtask

    // Present one request and hold it until accepted; push its expected response
    task automatic send(input int d, input logic op, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [7:0] opq, output int acc_cyc);
        msg_t m;
        int   n;
        @(negedge clk);
        req_val[d]  = 1'b1;
        req_op[d]   = op;
        req_addr[d] = addr;
        req_strb[d] = strb;
        req_data[d] = data;
        req_opq[d]  = opq;
        n       = 0;
        acc_cyc = -1;
        while (acc_cyc < 0) begin
            #1;
            if (req_rdy[d]) begin
                m.op   = op;
                m.opq  = opq;
                m.addr = addr;
                m.strb = strb;
                m.data = (op == OP_WR) ? 32'h0 : model_mem[d][addr[9:2]];
                if (op == OP_WR) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) model_mem[d][addr[9:2]][8*b +: 8] = data[8*b +: 8];
                    end
                end
                if (d == 0) exp_q0.push_back(m);
                else        exp_q1.push_back(m);
                @(posedge clk);
                #1;
                req_val[d] = 1'b0;
                acc_cyc    = cyc;
                $display("req  dut%0d cyc %0d op %0d opq %02h addr %08h strb %h data %08h",
                         d, cyc, op, opq, addr, strb, data);
            end else if (n >= 50) begin
                check_val("send_timeout", 128'(req_rdy[d]), 128'(1'b1));
                req_val[d] = 1'b0;
                acc_cyc    = cyc;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic wait_resp(input int d, input int n);
        int k = 0;
        while (rcyc_size(d) < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (rcyc_size(d) < n) check_val("resp_timeout", 128'(rcyc_size(d)), 128'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_val[d] = 1'b0; req_op[d] = OP_RD; req_opq[d] = '0; req_addr[d] = '0;
            req_strb[d] = '0; req_data[d] = '0; resp_rdy[d] = 1'b1;
            init_en[d] = 1'b0; init_addr[d] = '0; init_data[d] = '0; last_data[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("reset_req_rdy", 128'(req_rdy[d]), 128'(1'b0));
            check_val("reset_resp_val", 128'(resp_val[d]), 128'(1'b0));
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("post_reset_req_rdy", 128'(req_rdy[d]), 128'(1'b1));
            check_val("post_reset_resp_val", 128'(resp_val[d]), 128'(1'b0));
        end

        // Preloaded read, latency 1
        clear_rcyc(0);
        init_wr(0, 32'h10, 32'hDEADBEEF);
        send(0, OP_RD, 32'h10, 4'h0, 32'h0, 8'h5A, acc);
        wait_resp(0, 1);
        check_val("t1_latency", 128'(pop_rcyc(0)), 128'(acc));
        check_val("t1_data", 128'(last_data[0]), 128'(32'hDEADBEEF));

        // Strobed write then read
        clear_rcyc(0);
        init_wr(0, 32'h20, 32'h11223344);
        send(0, OP_WR, 32'h20, 4'b0110, 32'hAABBCCDD, 8'h01, acc);
        send(0, OP_RD, 32'h20, 4'h0, 32'h0, 8'h02, acc);
        wait_resp(0, 2);
        check_val("t2_read_merged", 128'(last_data[0]), 128'(32'h11BBCC44));

        // Back-to-back reads on the latency-2, depth-3 instance
        clear_rcyc(1);
        for (int i = 0; i < 4; i++) init_wr(1, 32'(i * 4), 32'hA0000000 + 32'(i));
        for (int i = 0; i < 4; i++) send(1, OP_RD, 32'(i * 4), 4'h0, 32'h0, 8'h10 + 8'(i), acc3[i]);
        for (int i = 1; i < 4; i++) check_val("t3_accept_cycle", 128'(acc3[i]), 128'(acc3[0] + i));
        wait_resp(1, 4);
        for (int i = 0; i < 4; i++) check_val("t3_resp_cycle", 128'(pop_rcyc(1)), 128'(acc3[0] + 1 + i));

        // Backpressure until full, then release
        clear_rcyc(0);
        @(negedge clk);
        resp_rdy[0] = 1'b0;
        fork
            begin
                send(0, OP_RD, 32'h10, 4'h0, 32'h0, 8'h41, acc4[0]);
                send(0, OP_RD, 32'h20, 4'h0, 32'h0, 8'h42, acc4[1]);
                send(0, OP_RD, 32'h10, 4'h0, 32'h0, 8'h43, acc4[2]);
            end
            begin
                repeat (5) @(negedge clk);
                #1;
                check_val("t4_stalled_resp_val", 128'(resp_val[0]), 128'(1'b1));
                check_val("t4_full_req_rdy", 128'(req_rdy[0]), 128'(1'b0));
                resp_rdy[0] = 1'b1;
            end
        join
        wait_resp(0, 3);
        r0 = pop_rcyc(0);
        r1 = pop_rcyc(0);
        r2 = pop_rcyc(0);
        check_val("t4_second_accept", 128'(acc4[1]), 128'(acc4[0] + 1));
        check_val("t4_back_to_back", 128'(r1), 128'(r0 + 1));
        check_val("t4_third_accept", 128'(acc4[2]), 128'(r0 + 2));
        check_val("t4_third_resp", 128'(r2), 128'(acc4[2]));

        // Address wrap modulo array size
        clear_rcyc(0);
        send(0, OP_WR, 32'h400, 4'hF, 32'h12345678, 8'h50, acc);
        send(0, OP_RD, 32'h000, 4'h0, 32'h0, 8'h51, acc);
        wait_resp(0, 2);
        check_val("t5_wrap_read", 128'(last_data[0]), 128'(32'h12345678));

        // Asynchronous reset with two requests outstanding
        clear_rcyc(0);
        @(negedge clk);
        resp_rdy[0] = 1'b0;
        send(0, OP_WR, 32'h30, 4'hF, 32'hCAFEF00D, 8'h60, acc);
        send(0, OP_RD, 32'h34, 4'h0, 32'h0, 8'h61, acc);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_resp_val", 128'(resp_val[0]), 128'(1'b0));
        check_val("t6_rst_req_rdy", 128'(req_rdy[0]), 128'(1'b0));
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n       = 1'b1;
        resp_rdy[0] = 1'b1;
        #1;
        check_val("t6_release_req_rdy", 128'(req_rdy[0]), 128'(1'b1));
        check_val("t6_release_resp_val", 128'(resp_val[0]), 128'(1'b0));
        repeat (5) @(negedge clk);
        check_val("t6_no_stale_resp", 128'(rcyc_size(0)), 128'(0));
        send(0, OP_RD, 32'h30, 4'h0, 32'h0, 8'h62, acc);
        wait_resp(0, 1);
        check_val("t6_write_survives", 128'(last_data[0]), 128'(32'hCAFEF00D));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
